// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor.
// Provides the FSM state type, the digit-counter width helper and the
// signed saturation constants used by the optional clamp.
package serial_subtractor_pkg;

    // Widest operand the saturation helpers can describe
    localparam int unsigned SAT_MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Digit counter width: $clog2(WIDTH/DIGIT), kept at least one bit wide
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
        int unsigned steps;
        steps = width / digit;
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    // Largest signed value at the given width (0111...1), LSB-aligned
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned width);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
            if (i + 1 < width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Smallest signed value at the given width (1000...0), LSB-aligned
    function automatic logic [SAT_MAX_W-1:0] sat_min(input int unsigned width);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
            if (i + 1 == width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_fa_cell.sv
// One-bit full adder cell used to build the per-cycle ripple slice.
// Ports: a, b, cin -> s (sum), cout (carry out).
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle two's-complement subtractor: diff = a + ~b + 1, computed
// DIGIT bits per cycle through a DIGIT-cell ripple slice over WIDTH/DIGIT
// cycles, with valid/ready handshakes on the operand and result sides.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  operand handshake (a minuend, b subtrahend)
//   out_valid/ready result handshake
//   diff            a - b modulo 2^WIDTH (clamped when saturation is enabled)
//   borrow          a < b as unsigned values
//   ovf             signed overflow
//   zero            diff == 0
//
// Build option: define SERIAL_SUB_SAT_EN to clamp diff to the signed
// max/min on overflow instead of wrapping.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CNT_W = cnt_width(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

`ifdef SERIAL_SUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               out_valid_q, out_valid_d;

    logic [DIGIT:0]     chain;
    logic [DIGIT-1:0]   sum;
    logic [WIDTH-1:0]   a_shift;
    logic [WIDTH-1:0]   b_shift;
    logic               ovf_c;
    logic [WIDTH-1:0]   final_c;

    // Ripple slice over the DIGIT LSBs of the operand registers
    assign chain[0] = carry_q;
    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        fa_cell u_fa (
            .a    (a_q[i]),
            .b    (b_q[i]),
            .cin  (chain[i]),
            .s    (sum[i]),
            .cout (chain[i+1])
        );
    end

    // The A register doubles as the result register: sum digits enter at
    // the MSB end as consumed minuend digits leave at the LSB end.
    if (DIGIT == WIDTH) begin : g_single
        assign a_shift = sum;
        assign b_shift = '0;
    end else begin : g_multi
        assign a_shift = {sum, a_q[WIDTH-1:DIGIT]};
        assign b_shift = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    end

    // Overflow from the captured operand signs and the wrapped result sign
    assign ovf_c = (sign_a_q != sign_b_q) && (a_shift[WIDTH-1] != sign_a_q);

`ifdef SERIAL_SUB_SAT_EN
    assign final_c = ovf_c ? (sign_a_q ? SAT_LO : SAT_HI) : a_shift;
`else
    assign final_c = a_shift;
`endif

    // Next-state and datapath next values
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = ~b;
                    carry_d  = 1'b1;
                    cnt_d    = '0;
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b[WIDTH-1];
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d     = a_shift;
                b_d     = b_shift;
                carry_d = chain[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    diff_d      = final_c;
                    borrow_d    = ~chain[DIGIT];
                    ovf_d       = ovf_c;
                    zero_d      = ~|final_c;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Ready drops combinationally while reset is held
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 with DIGIT=4 and DIGIT=1.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d_wrap;
        logic [W-1:0] d_sat;
        logic         br;
        logic         ov;
        logic         z;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst4, rst1, iv, ordy, which;
    logic [W-1:0] ta, tb;

    logic         in_valid4, in_ready4, out_valid4, out_ready4, borrow4, ovf4, zero4;
    logic         in_valid1, in_ready1, out_valid1, out_ready1, borrow1, ovf1, zero1;
    logic [W-1:0] diff4, diff1;

    logic         s_in_ready, s_out_valid, s_borrow, s_ovf, s_zero;
    logic [W-1:0] s_diff;

    int tests  = 0;
    int failed = 0;

    assign in_valid4  = iv & ~which;
    assign out_ready4 = ordy & ~which;
    assign in_valid1  = iv & which;
    assign out_ready1 = ordy & which;

    serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(ta), .b(tb), .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .borrow(borrow4), .ovf(ovf4), .zero(zero4)
    );

    serial_subtractor #(.WIDTH(W), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(ta), .b(tb), .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .borrow(borrow1), .ovf(ovf1), .zero(zero1)
    );

    always_comb begin
        if (which) begin
            s_in_ready = in_ready1; s_out_valid = out_valid1; s_diff = diff1;
            s_borrow = borrow1; s_ovf = ovf1; s_zero = zero1;
        end else begin
            s_in_ready = in_ready4; s_out_valid = out_valid4; s_diff = diff4;
            s_borrow = borrow4; s_ovf = ovf4; s_zero = zero4;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int g;
        g = 0;
        @(negedge clk);
        while (!s_in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({nm, " in_ready"}, 32'(s_in_ready), 32'd1);
    endtask

    // Accept one operation, measure latency to out_valid and check the result
    task automatic do_op(input string nm, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input int lat, input logic [W-1:0] ed, input logic eb,
                         input logic eo, input logic ez, input logic release_out);
        int cyc;
        wait_ready(nm);
        ta = oa; tb = ob; iv = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
        cyc = 0;
        while (!s_out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({nm, " latency"}, 32'(cyc), 32'(lat));
        check({nm, " diff"}, 32'(s_diff), 32'(ed));
        check({nm, " borrow"}, 32'(s_borrow), 32'(eb));
        check({nm, " ovf"}, 32'(s_ovf), 32'(eo));
        check({nm, " zero"}, 32'(s_zero), 32'(ez));
        check({nm, " busy"}, 32'(s_in_ready), 32'd0);
        if (release_out) begin
            @(negedge clk);
            ordy = 1'b1;
            @(posedge clk);
            #1 ordy = 1'b0;
            check({nm, " released"}, 32'(s_out_valid), 32'd0);
            check({nm, " diff kept"}, 32'(s_diff), 32'(ed));
        end
    endtask

    vec_t vecs[11];

    initial begin
        logic [W-1:0] ed;
        int cyc;

        //          a      b      wrap   sat    br    ov    z
        vecs[0]  = '{8'h35, 8'h12, 8'h23, 8'h23, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h12, 8'h35, 8'hDD, 8'hDD, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h80, 8'h01, 8'h7F, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{8'h7F, 8'hFF, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{8'h00, 8'h01, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{8'h80, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{8'h01, 8'h80, 8'h81, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{8'hA5, 8'h3C, 8'h69, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'h64, 8'h32, 8'h32, 8'h32, 1'b0, 1'b0, 1'b0};

        which = 1'b0; rst4 = 1'b1; rst1 = 1'b1; iv = 1'b0; ordy = 1'b0;
        ta = '0; tb = '0;

        // Reset values
        #12;
        check("rst in_ready", 32'(in_ready4), 32'd0);
        check("rst out_valid", 32'(out_valid4), 32'd0);
        check("rst diff", 32'(diff4), 32'd0);
        check("rst flags", 32'({borrow4, ovf4, zero4}), 32'd0);
        @(negedge clk);
        rst4 = 1'b0; rst1 = 1'b0;
        #1 check("idle in_ready", 32'(in_ready4), 32'd1);

        // Table vectors, DIGIT=4 (latency 2)
        for (int i = 0; i < 11; i++) begin
`ifdef SERIAL_SUB_SAT_EN
            ed = vecs[i].d_sat;
`else
            ed = vecs[i].d_wrap;
`endif
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 2, ed,
                  vecs[i].br, vecs[i].ov, vecs[i].z, 1'b1);
        end

        // Result stalled in HOLD while new operands are offered
        do_op("hold", 8'h5A, 8'h5A, 2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            iv = 1'b1; ta = 8'h44; tb = 8'h01;
            @(posedge clk);
            #1;
            check($sformatf("hold%0d valid", k), 32'(out_valid4), 32'd1);
            check($sformatf("hold%0d diff", k), 32'(diff4), 32'd0);
            check($sformatf("hold%0d zero", k), 32'(zero4), 32'd1);
            check($sformatf("hold%0d ready", k), 32'(in_ready4), 32'd0);
        end
        @(negedge clk);
        ordy = 1'b1; ta = 8'h11; tb = 8'h01;
        @(posedge clk);
        #1 ordy = 1'b0;
        check("hold handshake valid", 32'(out_valid4), 32'd0);
        check("hold handshake ready", 32'(in_ready4), 32'd1);
        check("hold handshake diff", 32'(diff4), 32'd0);
        @(posedge clk);
        #1 iv = 1'b0;
        check("hold next accepted", 32'(in_ready4), 32'd0);
        cyc = 0;
        while (!out_valid4 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("hold next latency", 32'(cyc), 32'd2);
        check("hold next diff", 32'(diff4), 32'h10);
        @(negedge clk);
        ordy = 1'b1;
        @(posedge clk);
        #1 ordy = 1'b0;

        // DIGIT=1: full operation, then reset mid-RUN
        which = 1'b1;
        do_op("d1 first", 8'h35, 8'h12, 8, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_ready("d1 abort");
        ta = 8'h80; tb = 8'h01; iv = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst1 = 1'b1;
        #1;
        check("abort out_valid", 32'(out_valid1), 32'd0);
        check("abort diff", 32'(diff1), 32'd0);
        check("abort flags", 32'({borrow1, ovf1, zero1}), 32'd0);
        check("abort in_ready", 32'(in_ready1), 32'd0);
        @(negedge clk);
        rst1 = 1'b0;
        #1 check("abort idle", 32'(in_ready1), 32'd1);
        do_op("d1 after", 8'h10, 8'h01, 8, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
